// File: rtl/npc_ras_unit.sv
// npc_ras_unit: architectural PC register, next-PC selection and a circular
// return-address stack (RAS) used as a call/return predictor, with a saturating
// counter of committed return mispredictions.
module npc_ras_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       npc_op,
  input  logic             br_cond,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] reg_rd,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_4,
  output logic [WIDTH-1:0] npc,
  output logic             pc_misalign,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_miss,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned    PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_JAL  = 3'd2,
    OP_JR   = 3'd3,
    OP_J    = 3'd4,
    OP_JALR = 3'd5,
    OP_RET  = 3'd6,
    OP_RSV  = 3'd7
  } npc_op_e;

  npc_op_e          op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d, push_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             push_op, pop_op;
  logic             do_push, do_pop;

  assign op          = npc_op_e'(npc_op);
  assign pc          = pc_q;
  assign pc_plus_4   = pc_q + WIDTH'(4);
  assign pc_misalign = |pc_q[1:0];
  assign jump_tgt    = {pc_q[WIDTH-1:28], imm26, 2'b00};
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == DEPTH_C);
  assign ras_top     = ras_q[top_q];
  assign push_idx    = top_q + PTR_W'(1);
  assign miss_cnt    = miss_q;

  // Next-PC selection and RAS action decode for the current op.
  always_comb begin
    npc     = pc_plus_4;
    push_op = 1'b0;
    pop_op  = 1'b0;
    unique case (op)
      OP_BR:   npc = br_cond ? (pc_plus_4 + imm_ext) : pc_plus_4;
      OP_JAL:  begin npc = jump_tgt; push_op = 1'b1; end
      OP_JR:   npc = reg_rd;
      OP_J:    npc = jump_tgt;
      OP_JALR: begin npc = reg_rd; push_op = 1'b1; end
      OP_RET:  begin npc = reg_rd; pop_op = 1'b1; end
      default: npc = pc_plus_4;
    endcase
  end

  // Return prediction check: an empty stack always counts as a miss.
  always_comb begin
    ras_miss = (op == OP_RET) && (ras_empty || (ras_top != reg_rd));
  end

  // Commit-time next state for PC, stack pointers and the miss counter.
  always_comb begin
    do_push = en && push_op;
    do_pop  = en && pop_op && !ras_empty;
    pc_d    = en ? npc : pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    if (do_push) begin
      // Pushing onto a full stack wraps over the oldest entry.
      top_d = push_idx;
      cnt_d = ras_full ? cnt_q : cnt_q + 1'b1;
    end else if (do_pop) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - 1'b1;
    end
    if (en && ras_miss && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end
  end

  // Architectural state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= WIDTH'(RESET_PC);
      top_q  <= '0;
      cnt_q  <= '0;
      miss_q <= '0;
    end else begin
      pc_q   <= pc_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end

  // Stack storage; contents are only meaningful below the valid count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_q[push_idx] <= pc_plus_4;
    end
  end

endmodule

// File: tb/tb_npc_ras_unit.sv
// Self-checking bench for npc_ras_unit: constant vector table, directed
// multi-cycle sequences and random stimulus against a queue-based model.
module tb_npc_ras_unit;

  localparam int unsigned D = 4;

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JAL = 3'd2, JR = 3'd3,
                         J = 3'd4, JALR = 3'd5, RET = 3'd6, RSV = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  npc_op;
  logic        br_cond;
  logic [31:0] imm_ext;
  logic [25:0] imm26;
  logic [31:0] reg_rd;

  logic [31:0] pc, pc_plus_4, npc;
  logic        pc_misalign, ras_empty, ras_full, ras_miss;
  logic [15:0] miss_cnt;

  logic [31:0] s_pc, s_pc_plus_4, s_npc;
  logic        s_pc_misalign, s_ras_empty, s_ras_full, s_ras_miss;
  logic [1:0]  s_miss_cnt;

  npc_ras_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000), .RAS_DEPTH(D), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .en(en), .npc_op(npc_op), .br_cond(br_cond),
    .imm_ext(imm_ext), .imm26(imm26), .reg_rd(reg_rd),
    .pc(pc), .pc_plus_4(pc_plus_4), .npc(npc), .pc_misalign(pc_misalign),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss), .miss_cnt(miss_cnt)
  );

  // Narrow counter instance so saturation is reachable quickly.
  npc_ras_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000), .RAS_DEPTH(D), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .en(en), .npc_op(npc_op), .br_cond(br_cond),
    .imm_ext(imm_ext), .imm26(imm26), .reg_rd(reg_rd),
    .pc(s_pc), .pc_plus_4(s_pc_plus_4), .npc(s_npc), .pc_misalign(s_pc_misalign),
    .ras_empty(s_ras_empty), .ras_full(s_ras_full), .ras_miss(s_ras_miss), .miss_cnt(s_miss_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: PC plus a bounded list of return addresses (newest last).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int unsigned m_cnt;

  function automatic logic [31:0] m_npc(input logic [2:0] op, input logic b,
                                        input logic [31:0] imm, input logic [25:0] i26,
                                        input logic [31:0] rd, input logic [31:0] p);
    logic [31:0] seq;
    seq = p + 32'd4;
    case (op)
      BR:            return b ? seq + imm : seq;
      JAL, J:        return {p[31:28], i26, 2'b00};
      JR, JALR, RET: return rd;
      default:       return seq;
    endcase
  endfunction

  function automatic logic m_miss(input logic [2:0] op, input logic [31:0] rd);
    if (op != RET) return 1'b0;
    if (m_ras.size() == 0) return 1'b1;
    return m_ras[$] != rd;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc_plus_4, m_pc + 32'd4);
    chk({tag, ".misalign"}, {31'd0, pc_misalign}, {31'd0, |m_pc[1:0]});
    chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    chk({tag, ".full"}, {31'd0, ras_full}, {31'd0, m_ras.size() == D});
    chk({tag, ".cnt"}, {16'd0, miss_cnt}, m_cnt);
    chk({tag, ".satcnt"}, {30'd0, s_miss_cnt}, (m_cnt > 3) ? 32'd3 : m_cnt);
  endtask

  task automatic apply_reset(input string tag);
    en     = 1'b0;
    npc_op = SEQ;
    #2;
    reset = 1'b1;
    #1;
    m_pc = 32'h0000_3000;
    m_ras.delete();
    m_cnt = 0;
    check_state(tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Drive one op, check combinational outputs, clock it, update model, check state.
  task automatic do_op(input string tag, input logic [2:0] op, input logic b,
                       input logic [31:0] imm, input logic [25:0] i26,
                       input logic [31:0] rd, input logic e, output logic miss_o);
    logic [31:0] exp_npc;
    logic        exp_miss;
    npc_op = op; br_cond = b; imm_ext = imm; imm26 = i26; reg_rd = rd; en = e;
    #1;
    exp_npc  = m_npc(op, b, imm, i26, rd, m_pc);
    exp_miss = m_miss(op, rd);
    chk({tag, ".npc"}, npc, exp_npc);
    chk({tag, ".miss"}, {31'd0, ras_miss}, {31'd0, exp_miss});
    miss_o = ras_miss;
    @(posedge clk);
    #1;
    if (e) begin
      if (exp_miss) m_cnt++;
      if (op == RET && m_ras.size() > 0) void'(m_ras.pop_back());
      if (op == JAL || op == JALR) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > D) void'(m_ras.pop_front());
      end
      m_pc = exp_npc;
    end
    check_state(tag);
  endtask

  typedef struct {
    logic [31:0] start_pc;
    logic [2:0]  op;
    logic        b;
    logic [31:0] imm;
    logic [25:0] i26;
    logic [31:0] rd;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic m;
    reset = 1'b0; en = 1'b0; npc_op = SEQ; br_cond = 1'b0;
    imm_ext = '0; imm26 = '0; reg_rd = '0;

    tbl[0]  = '{32'h0000_3010, BR,   1'b1, 32'hFFFF_FFF8, 26'h0,       32'h0,         32'h0000_300C};
    tbl[1]  = '{32'h0000_3010, BR,   1'b0, 32'hFFFF_FFF8, 26'h0,       32'h0,         32'h0000_3014};
    tbl[2]  = '{32'h0000_3020, JAL,  1'b0, 32'h0,         26'h0000C40, 32'h0,         32'h0000_3100};
    tbl[3]  = '{32'hF000_3020, J,    1'b0, 32'h0,         26'h3FFFFFF, 32'h0,         32'hFFFF_FFFC};
    tbl[4]  = '{32'h0000_3000, JR,   1'b0, 32'h0,         26'h0,       32'h1234_5678, 32'h1234_5678};
    tbl[5]  = '{32'h0000_3000, JALR, 1'b0, 32'h0,         26'h0,       32'h0000_5000, 32'h0000_5000};
    tbl[6]  = '{32'h0000_3000, RSV,  1'b1, 32'h40,        26'h1,       32'h0000_9999, 32'h0000_3004};
    tbl[7]  = '{32'hFFFF_FFFC, SEQ,  1'b0, 32'h0,         26'h0,       32'h0,         32'h0000_0000};
    tbl[8]  = '{32'hFFFF_FFF0, BR,   1'b1, 32'h0000_0020, 26'h0,       32'h0,         32'h0000_0014};
    tbl[9]  = '{32'h0000_3000, RET,  1'b0, 32'h0,         26'h0,       32'h0000_4444, 32'h0000_4444};
    tbl[10] = '{32'h1234_5670, J,    1'b0, 32'h0,         26'h0000001, 32'h0,         32'h1000_0004};
    tbl[11] = '{32'h0000_3000, SEQ,  1'b1, 32'hFFFF_0000, 26'h3FFFFFF, 32'hDEAD_BEEF, 32'h0000_3004};

    // 1: reset then sequential flow
    apply_reset("t1.rst");
    chk("t1.rst_pc", pc, 32'h0000_3000);
    chk("t1.rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("t1.rst_cnt", {16'd0, miss_cnt}, 32'd0);
    for (int unsigned i = 1; i <= 3; i++) begin
      do_op("t1.seq", SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, m);
      chk("t1.seq_pc", pc, 32'h0000_3000 + 32'(4 * i));
      chk("t1.seq_mis", {31'd0, pc_misalign}, 32'd0);
    end

    // 2: table-driven single-op vectors
    for (int unsigned i = 0; i < 12; i++) begin
      do_op("t2.set", JR, 1'b0, 32'h0, 26'h0, tbl[i].start_pc, 1'b1, m);
      do_op("t2.vec", tbl[i].op, tbl[i].b, tbl[i].imm, tbl[i].i26, tbl[i].rd, 1'b1, m);
      chk("t2.vec_pc", pc, tbl[i].exp_pc);
    end

    // 3: call / matching return
    apply_reset("t3.rst");
    do_op("t3.set", JR, 1'b0, 32'h0, 26'h0, 32'h0000_3020, 1'b1, m);
    do_op("t3.jal", JAL, 1'b0, 32'h0, 26'h0000C40, 32'h0, 1'b1, m);
    chk("t3.jal_pc", pc, 32'h0000_3100);
    chk("t3.jal_empty", {31'd0, ras_empty}, 32'd0);
    do_op("t3.ret", RET, 1'b0, 32'h0, 26'h0, 32'h0000_3024, 1'b1, m);
    chk("t3.ret_miss", {31'd0, m}, 32'd0);
    chk("t3.ret_pc", pc, 32'h0000_3024);
    chk("t3.ret_empty", {31'd0, ras_empty}, 32'd1);
    chk("t3.ret_cnt", {16'd0, miss_cnt}, 32'd0);

    // 4: overflow wrap then underflow
    apply_reset("t4.rst");
    for (int unsigned i = 0; i < 5; i++) begin
      do_op("t4.set", JR, 1'b0, 32'h0, 26'h0, 32'h0000_3000 + 32'(i * 32'h100), 1'b1, m);
      do_op("t4.jal", JAL, 1'b0, 32'h0, 26'h0000C00, 32'h0, 1'b1, m);
    end
    chk("t4.full", {31'd0, ras_full}, 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      do_op("t4.ret", RET, 1'b0, 32'h0, 26'h0, 32'h0000_3404 - 32'(i * 32'h100), 1'b1, m);
      chk("t4.ret_miss", {31'd0, m}, 32'd0);
    end
    do_op("t4.ret5", RET, 1'b0, 32'h0, 26'h0, 32'h0000_3004, 1'b1, m);
    chk("t4.ret5_miss", {31'd0, m}, 32'd1);
    chk("t4.ret5_pc", pc, 32'h0000_3004);
    chk("t4.ret5_cnt", {16'd0, miss_cnt}, 32'd1);

    // 5: stall holds everything while RET is presented
    apply_reset("t5.rst");
    do_op("t5.jalr", JALR, 1'b0, 32'h0, 26'h0, 32'h0000_6000, 1'b1, m);
    for (int unsigned i = 0; i < 3; i++) begin
      do_op("t5.stall", RET, 1'b0, 32'h0, 26'h0, 32'h0000_7777, 1'b0, m);
      chk("t5.stall_miss", {31'd0, m}, 32'd1);
      chk("t5.stall_pc", pc, 32'h0000_6000);
      chk("t5.stall_empty", {31'd0, ras_empty}, 32'd0);
      chk("t5.stall_cnt", {16'd0, miss_cnt}, 32'd0);
    end
    do_op("t5.go", RET, 1'b0, 32'h0, 26'h0, 32'h0000_3004, 1'b1, m);
    chk("t5.go_pc", pc, 32'h0000_3004);
    chk("t5.go_empty", {31'd0, ras_empty}, 32'd1);
    chk("t5.go_cnt", {16'd0, miss_cnt}, 32'd0);

    // 6: asynchronous reset mid-cycle, then misaligned jump target
    apply_reset("t6.rst");
    for (int unsigned i = 0; i < 3; i++)
      do_op("t6.miss", RET, 1'b0, 32'h0, 26'h0, 32'h0000_3000, 1'b1, m);
    chk("t6.cnt3", {16'd0, miss_cnt}, 32'd3);
    do_op("t6.jal", JAL, 1'b0, 32'h0, 26'h0000C40, 32'h0, 1'b1, m);
    do_op("t6.jal", JAL, 1'b0, 32'h0, 26'h0000C80, 32'h0, 1'b1, m);
    chk("t6.pre_empty", {31'd0, ras_empty}, 32'd0);
    en = 1'b1;
    npc_op = SEQ;
    #2;
    reset = 1'b1;
    #1;
    chk("t6.async_pc", pc, 32'h0000_3000);
    chk("t6.async_empty", {31'd0, ras_empty}, 32'd1);
    chk("t6.async_cnt", {16'd0, miss_cnt}, 32'd0);
    m_pc = 32'h0000_3000; m_ras.delete(); m_cnt = 0;
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    do_op("t6.jr", JR, 1'b0, 32'h0, 26'h0, 32'h0000_3002, 1'b1, m);
    chk("t6.misalign", {31'd0, pc_misalign}, 32'd1);
    chk("t6.mis_pc", pc, 32'h0000_3002);

    // Counter saturation on the narrow instance
    apply_reset("tsat.rst");
    for (int unsigned i = 0; i < 5; i++)
      do_op("tsat.miss", RET, 1'b0, 32'h0, 26'h0, 32'h0000_3000, 1'b1, m);
    chk("tsat.sat", {30'd0, s_miss_cnt}, 32'd3);
    chk("tsat.wide", {16'd0, miss_cnt}, 32'd5);

    // Random stimulus against the model
    apply_reset("trnd.rst");
    for (int unsigned i = 0; i < 600; i++) begin
      logic [2:0]  op;
      logic [31:0] rd;
      logic [31:0] imm;
      op  = 3'($urandom_range(0, 7));
      imm = {{20{$urandom_range(0, 1) == 1}}, 12'($urandom_range(0, 4095))} & 32'hFFFF_FFFC;
      rd  = $urandom() & 32'hFFFF_FFFC;
      if (op == RET && m_ras.size() > 0 && $urandom_range(0, 3) != 0) rd = m_ras[$];
      if ($urandom_range(0, 31) == 0) rd = rd | 32'h2;
      do_op("trnd", op, 1'($urandom_range(0, 1)), imm, 26'($urandom()), rd,
            $urandom_range(0, 3) != 0, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
